// File: rtl/sd_block_reader_pkg.sv
// Shared constants and state encoding for the SD single-block read path.
package sd_block_reader_pkg;

  localparam logic [7:0]  START_TOKEN    = 8'hFE;
  localparam logic [2:0]  ERR_TOKEN_MASK = 3'b000;
  localparam logic [15:0] CRC16_POLY     = 16'h1021;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_TOKEN = 3'd1,
    DATA       = 3'd2,
    CRC        = 3'd3,
    FINISH     = 3'd4
  } state_t;

endpackage

// File: rtl/sd_crc16.sv
// Serial CRC16-CCITT (poly 0x1021, init 0), one data bit per enable, MSB first.
module sd_crc16
  import sd_block_reader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc
);

  logic fb;

  always_comb fb = crc[15] ^ din;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       crc <= '0;
    else if (clear) crc <= '0;
    else if (en)    crc <= {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  end

endmodule

// File: rtl/sd_block_reader.sv
// Reads one SD data block over SPI after CMD17: start token, payload, CRC16,
// then streams payload bytes out over valid/ready and reports status.
module sd_block_reader
  import sd_block_reader_pkg::*;
#(
  parameter int CLK_DIV       = 2,
  parameter int BLOCK_BYTES   = 512,
  parameter int TOKEN_TIMEOUT = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       miso,
  output logic       sdclk,
  output logic       mosi,
  output logic       busy,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       done,
  output logic       crc_ok,
  output logic       err_timeout,
  output logic       err_token,
  output logic [3:0] err_code
);

  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_MAX = (BLOCK_BYTES > TOKEN_TIMEOUT) ? BLOCK_BYTES : TOKEN_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [DIV_W-1:0] DIV_TC     = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BLOCK_LAST = CNT_W'(BLOCK_BYTES - 1);
  localparam logic [CNT_W-1:0] TOKEN_LAST = CNT_W'(TOKEN_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic             running;
  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift;
  logic [CNT_W-1:0] byte_cnt;
  logic [7:0]       crc_hi;
  logic [15:0]      crc;
  logic             tc, rise, byte_done, start_byte, accept, launch;

  assign mosi = 1'b1;

  always_comb begin
    tc        = running && (div_cnt == DIV_TC);
    rise      = tc && !sdclk;
    byte_done = tc && sdclk && (bit_cnt == 3'd7);
    accept    = data_valid && data_ready;
    launch    = (state_q == IDLE) && start;
  end

  always_comb begin
    state_d    = state_q;
    start_byte = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = WAIT_TOKEN;
      WAIT_TOKEN: begin
        start_byte = !running;
        if (byte_done) begin
          if (shift == START_TOKEN) state_d = DATA;
          else if (shift[7:5] == ERR_TOKEN_MASK || byte_cnt == TOKEN_LAST) state_d = FINISH;
        end
      end
      DATA: begin
        // holding a byte the consumer has not taken: leave sdclk parked low
        start_byte = !running && !(data_valid && !data_ready);
        if (byte_done && byte_cnt == BLOCK_LAST) state_d = CRC;
      end
      CRC: begin
        start_byte = !running;
        if (byte_done && byte_cnt[0]) state_d = FINISH;
      end
      FINISH: begin
        start_byte = !running && !data_valid;
        if (byte_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Byte engine: 8 sdclk periods, sample on the rising edge, stop after the 8th fall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      running <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      sdclk   <= 1'b0;
      shift   <= '0;
    end else if (start_byte) begin
      running <= 1'b1;
      div_cnt <= '0;
      bit_cnt <= '0;
    end else if (running) begin
      if (tc) begin
        div_cnt <= '0;
        sdclk   <= !sdclk;
        if (rise)                shift   <= {shift[6:0], miso};
        else if (bit_cnt == 3'd7) running <= 1'b0;
        else                     bit_cnt <= bit_cnt + 3'd1;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      crc_ok      <= 1'b0;
      err_timeout <= 1'b0;
      err_token   <= 1'b0;
      err_code    <= '0;
      byte_cnt    <= '0;
      crc_hi      <= '0;
    end else begin
      state_q <= state_d;
      done    <= 1'b0;
      if (state_d != state_q) byte_cnt <= '0;
      else if (byte_done)     byte_cnt <= byte_cnt + CNT_W'(1);
      if (launch) begin
        busy        <= 1'b1;
        crc_ok      <= 1'b0;
        err_timeout <= 1'b0;
        err_token   <= 1'b0;
        err_code    <= '0;
      end
      if (byte_done) begin
        case (state_q)
          WAIT_TOKEN: if (shift != START_TOKEN) begin
            if (shift[7:5] == ERR_TOKEN_MASK) begin
              err_token <= 1'b1;
              err_code  <= shift[3:0];
            end else if (byte_cnt == TOKEN_LAST) begin
              err_timeout <= 1'b1;
            end
          end
          CRC: if (!byte_cnt[0]) crc_hi <= shift;
               else              crc_ok <= ({crc_hi, shift} == crc);
          FINISH: begin
            done <= 1'b1;
            busy <= 1'b0;
          end
          default: ;
        endcase
      end
      if (byte_done && state_q == DATA) begin
        data_out   <= shift;
        data_valid <= 1'b1;
      end else if (accept) begin
        data_valid <= 1'b0;
      end
    end
  end

  sd_crc16 u_crc (
    .clk   (clk),
    .rst   (rst),
    .clear (launch),
    .en    (rise && state_q == DATA),
    .din   (miso),
    .crc   (crc)
  );

endmodule

// File: tb/tb_sd_block_reader.sv
// Self-checking bench for sd_block_reader: SPI card model, byte-level reference model,
// table of token/timeout vectors, directed block sequences and randomized operations.
module tb_sd_block_reader;

  localparam int CLK_DIV = 1;
  localparam int BLK     = 512;
  localparam int TOUT    = 16;

  logic       clk = 1'b0;
  logic       rst, start, miso, sdclk, mosi, busy, data_valid, data_ready;
  logic       done, crc_ok, err_timeout, err_token;
  logic [7:0] data_out;
  logic [3:0] err_code;

  int n_checks = 0;
  int n_errors = 0;

  sd_block_reader #(.CLK_DIV(CLK_DIV), .BLOCK_BYTES(BLK), .TOKEN_TIMEOUT(TOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .miso(miso), .sdclk(sdclk), .mosi(mosi),
    .busy(busy), .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
    .done(done), .crc_ok(crc_ok), .err_timeout(err_timeout), .err_token(err_token),
    .err_code(err_code)
  );

  always #5 clk = ~clk;

  // ---------------- card model: shifts bits out, advancing on sdclk falls
  logic       card_bits [0:8191];
  int         card_len  = 0;
  int         card_base = 0;
  int         rd_cnt    = 0;
  int         rise_cnt  = 0;
  int         card_idx;
  logic [7:0] stream [$];

  always @(negedge sdclk) rd_cnt++;
  always @(posedge sdclk) rise_cnt++;

  always_comb begin
    card_idx = rd_cnt - card_base;
    miso = (card_idx >= 0 && card_idx < card_len) ? card_bits[card_idx[12:0]] : 1'b1;
  end

  // ---------------- monitor
  logic [7:0] rx_q [$];
  int rx_n = 0, dv_cnt = 0, done_n = 0;

  always @(negedge clk) begin
    if (data_valid) dv_cnt++;
    if (data_valid && data_ready) begin
      rx_q.push_back(data_out);
      rx_n++;
    end
    if (done) done_n++;
  end

  // ---------------- consumer: 0 always ready, 1 random, 2 stall 40 cycles at byte 10
  int ready_mode = 0;
  int bp_done = 0, bp_bad = 0, rx_base = 0;

  initial begin
    data_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        1: data_ready = ($urandom_range(0, 3) != 0);
        2: begin
          if (bp_done == 0 && data_valid && (rx_n - rx_base) == 10) begin
            data_ready = 1'b0;
            bp_done = 1;
            repeat (40) begin
              @(negedge clk);
              if (sdclk || !data_valid || data_out != 8'h0A) bp_bad++;
              @(posedge clk); #1;
            end
          end
          data_ready = 1'b1;
        end
        default: data_ready = 1'b1;
      endcase
    end
  end

  // ---------------- reference model
  logic [7:0] exp_q [$];
  int         m_kind, m_used;
  logic [3:0] m_code;
  logic       m_crc_ok;

  function automatic logic [7:0] byte_at(input int i);
    return (i < stream.size()) ? stream[i] : 8'hFF;
  endfunction

  function automatic logic [15:0] crc16_of(input logic [7:0] q[$]);
    logic [15:0] c = 16'h0000;
    foreach (q[k]) begin
      c = c ^ {q[k], 8'h00};
      for (int b = 0; b < 8; b++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  // kind: 0 block read, 1 error token, 2 token timeout; m_used = bytes clocked before release
  task automatic model();
    int i = 0, waited = 0;
    logic [7:0] b;
    exp_q.delete();
    m_kind = 0; m_code = 4'h0; m_crc_ok = 1'b0;
    while (1) begin
      b = byte_at(i); i++;
      if (b == 8'hFE) break;
      if (b[7:5] == 3'b000) begin m_kind = 1; m_code = b[3:0]; m_used = i; return; end
      waited++;
      if (waited == TOUT) begin m_kind = 2; m_used = i; return; end
    end
    for (int k = 0; k < BLK; k++) exp_q.push_back(byte_at(i + k));
    m_crc_ok = (crc16_of(exp_q) == {byte_at(i + BLK), byte_at(i + BLK + 1)});
    m_used = i + BLK + 2;
  endtask

  // ---------------- helpers
  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic load_card();
    card_len = 0;
    card_base = rd_cnt;
    foreach (stream[k]) for (int b = 7; b >= 0; b--) begin
      card_bits[card_len] = stream[k][b];
      card_len++;
    end
  endtask

  task automatic build_block(input bit rnd, input bit corrupt);
    logic [7:0] d [$];
    logic [15:0] c;
    logic [7:0] b;
    int n;
    stream.delete();
    n = rnd ? $urandom_range(0, 10) : 3;
    repeat (n) begin
      b = rnd ? 8'($urandom_range(32, 255)) : 8'hFF;
      stream.push_back(b == 8'hFE ? 8'hFF : b);
    end
    stream.push_back(8'hFE);
    for (int k = 0; k < BLK; k++) d.push_back(rnd ? 8'($urandom) : 8'(k));
    c = crc16_of(d);
    foreach (d[k]) stream.push_back(d[k]);
    stream.push_back(c[15:8]);
    stream.push_back(corrupt ? ~c[7:0] : c[7:0]);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  int got_beats, got_rises, got_dv, rise_base, dv_base, done_base;

  task automatic run_op(input int rmode, input bit dup_start);
    int t;
    load_card();
    rx_base = rx_n; rise_base = rise_cnt; dv_base = dv_cnt; done_base = done_n;
    bp_done = 0; bp_bad = 0;
    ready_mode = rmode;
    pulse_start();
    check("busy_on", busy, 1);
    t = 0;
    while (done_n == done_base && t < 30000) begin
      @(posedge clk); #1;
      start = dup_start && (t == 200);
      t++;
    end
    start = 1'b0;
    check("done_seen", done_n - done_base, 1);
    check("done_width", done, 0);
    check("busy_off", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    got_beats = rx_n - rx_base;
    got_rises = rise_cnt - rise_base;
    got_dv    = dv_cnt - dv_base;
    ready_mode = 0;
  endtask

  task automatic check_vs_model(input string tag);
    int bad = 0;
    model();
    check({tag, "_err_timeout"}, err_timeout, m_kind == 2);
    check({tag, "_err_token"}, err_token, m_kind == 1);
    check({tag, "_err_code"}, err_code, (m_kind == 1) ? m_code : 4'h0);
    check({tag, "_crc_ok"}, crc_ok, (m_kind == 0) && m_crc_ok);
    check({tag, "_beats"}, got_beats, (m_kind == 0) ? BLK : 0);
    check({tag, "_rises"}, got_rises, 8 * m_used + 8);
    for (int k = 0; k < exp_q.size() && k < got_beats; k++)
      if (rx_q[rx_base + k] != exp_q[k]) bad++;
    check({tag, "_data"}, bad, 0);
  endtask

  // ---------------- table of token-phase vectors
  typedef struct {
    int         n_ff;
    logic [7:0] tail;
    logic       exp_tout;
    logic       exp_tok;
    logic [3:0] exp_code;
    int         exp_rises;
  } vec_t;

  vec_t vecs [6];

  initial begin
    rst = 1'b0; start = 1'b0;
    vecs[0] = '{1,  8'h09, 1'b0, 1'b1, 4'h9, 24};
    vecs[1] = '{0,  8'h00, 1'b0, 1'b1, 4'h0, 16};
    vecs[2] = '{5,  8'h1F, 1'b0, 1'b1, 4'hF, 56};
    vecs[3] = '{20, 8'h05, 1'b1, 1'b0, 4'h0, 136};
    vecs[4] = '{15, 8'h03, 1'b0, 1'b1, 4'h3, 136};
    vecs[5] = '{0,  8'h20, 1'b1, 1'b0, 4'h0, 136};

    #23;
    check("rst_sdclk", sdclk, 0);
    check("rst_mosi", mosi, 1);
    check("rst_busy", busy, 0);
    check("rst_valid", data_valid, 0);
    check("rst_done", done, 0);
    check("rst_flags", {crc_ok, err_timeout, err_token, err_code, data_out}, 0);
    @(posedge clk); #1 rst = 1'b1;

    for (int v = 0; v < 6; v++) begin
      stream.delete();
      repeat (vecs[v].n_ff) stream.push_back(8'hFF);
      stream.push_back(vecs[v].tail);
      run_op(0, 1'b0);
      check($sformatf("tbl%0d_err_timeout", v), err_timeout, vecs[v].exp_tout);
      check($sformatf("tbl%0d_err_token", v), err_token, vecs[v].exp_tok);
      check($sformatf("tbl%0d_err_code", v), err_code, vecs[v].exp_code);
      check($sformatf("tbl%0d_crc_ok", v), crc_ok, 0);
      check($sformatf("tbl%0d_no_valid", v), got_dv, 0);
      check($sformatf("tbl%0d_rises", v), got_rises, vecs[v].exp_rises);
    end

    // nominal block, with a stray start mid-read that must be ignored
    build_block(1'b0, 1'b0);
    run_op(0, 1'b1);
    check_vs_model("nominal");
    check("nominal_crc_ok", crc_ok, 1);

    build_block(1'b0, 1'b1);
    run_op(0, 1'b0);
    check_vs_model("badcrc");

    build_block(1'b0, 1'b0);
    run_op(2, 1'b0);
    check_vs_model("backpressure");
    check("bp_stalled", bp_done, 1);
    check("bp_hold", bp_bad, 0);

    // reset in the middle of the payload
    begin
      int t = 0;
      build_block(1'b0, 1'b0);
      load_card();
      rx_base = rx_n; done_base = done_n;
      ready_mode = 0;
      pulse_start();
      while ((rx_n - rx_base) < 100 && t < 5000) begin @(posedge clk); #1; t++; end
      check("rst_mid_reached", (rx_n - rx_base) >= 100, 1);
      rst = 1'b0;
      #1;
      check("rst_mid_sdclk", sdclk, 0);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_valid", data_valid, 0);
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("rst_mid_no_done", done_n - done_base, 0);
    end
    build_block(1'b0, 1'b0);
    run_op(0, 1'b0);
    check_vs_model("after_rst");

    // randomized operations against the model
    for (int i = 0; i < 6; i++) begin
      logic [7:0] b;
      case (i % 3)
        0: build_block(1'b1, ($urandom_range(0, 1) == 1));
        1: begin
          stream.delete();
          repeat ($urandom_range(0, 15)) begin
            b = 8'($urandom_range(32, 255));
            stream.push_back(b == 8'hFE ? 8'hFF : b);
          end
          stream.push_back(8'($urandom_range(0, 31)));
        end
        default: begin
          stream.delete();
          repeat ($urandom_range(TOUT, TOUT + 8)) begin
            b = 8'($urandom_range(32, 255));
            stream.push_back(b == 8'hFE ? 8'hFF : b);
          end
        end
      endcase
      run_op((i % 3 == 0) ? 1 : 0, 1'b0);
      check_vs_model($sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
